// File: rtl/boron_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : boron_key_schedule
// Description : Iterative BORON key schedule. Generates 26 x 64-bit round keys,
//               one per clock, into a buffer read through a registered port.
//               Define BORON_KEY128_EN for the 128-bit key variant.
// Revision    : 1.0 - initial release
// ============================================================================
module boron_key_schedule #(
    parameter int NRK = 26,
    parameter int RKW = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             keyStart,
    input  logic [127:0]     key,
    input  logic [4:0]       rk_addr,
    output logic [RKW-1:0]   rk_out,
    output logic             keyDone,
    output logic             busy
);

`ifdef BORON_KEY128_EN
    localparam int KW = 128;
`else
    localparam int KW = 80;
    // The upper key bits are deliberately ignored by the 80-bit schedule.
    logic w_unused_key_hi;
    assign w_unused_key_hi = ^key[127:80];
`endif

    localparam logic [4:0] c_last_idx = 5'(NRK - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_GEN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_last;
    logic [KW-1:0]    r_k;
    logic [4:0]       r_cnt;
    logic [RKW-1:0]   r_rk [NRK];

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;
            4'h1: y = 4'h4;
            4'h2: y = 4'hB;
            4'h3: y = 4'h1;
            4'h4: y = 4'h7;
            4'h5: y = 4'h9;
            4'h6: y = 4'hC;
            4'h7: y = 4'hA;
            4'h8: y = 4'hD;
            4'h9: y = 4'h2;
            4'hA: y = 4'h0;
            4'hB: y = 4'hF;
            4'hC: y = 4'h8;
            4'hD: y = 4'h5;
            4'hE: y = 4'h3;
            default: y = 4'h6;
        endcase
        return y;
    endfunction

    function automatic logic [KW-1:0] key_update(input logic [KW-1:0] k, input logic [4:0] i);
        logic [KW-1:0] t;
        t = {k[KW-14:0], k[KW-1:KW-13]};
        t[3:0] = sbox(t[3:0]);
`ifdef BORON_KEY128_EN
        t[7:4] = sbox(t[7:4]);
`endif
        t[63:59] = t[63:59] ^ i;
        return t;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (keyStart) begin
                    w_accept     = 1'b1;
                    w_state_next = S_GEN;
                end
            end
            S_GEN: begin
                if (r_cnt == c_last_idx) begin
                    w_last       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_k     <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            keyDone <= 1'b0;
            rk_out  <= '0;
        end else begin
            keyDone <= w_last;
            if (w_accept) begin
                r_k   <= key[KW-1:0];
                r_cnt <= '0;
                busy  <= 1'b1;
            end else if (r_state == S_GEN) begin
                if (w_last) begin
                    busy <= 1'b0;
                end else begin
                    r_k   <= key_update(r_k, r_cnt + 5'd1);
                    r_cnt <= r_cnt + 5'd1;
                end
            end
            // Reads see the buffer before this edge's write: no bypass.
            rk_out <= (rk_addr <= c_last_idx) ? r_rk[rk_addr] : '0;
        end
    end

    // Round-key storage is intentionally left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (!reset && r_state == S_GEN) begin
            r_rk[r_cnt] <= r_k[RKW-1:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_boron_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_boron_key_schedule
// Description : Directed self-checking bench for boron_key_schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boron_key_schedule;

`ifdef BORON_KEY128_EN
    localparam int KW = 128;
    localparam logic [63:0] c_zero_rk1 = 64'h08000000000000EE;
    localparam logic [63:0] c_zero_rk2 = 64'h10000000001DC0EE;
`else
    localparam int KW = 80;
    localparam logic [63:0] c_zero_rk1 = 64'h080000000000000E;
    localparam logic [63:0] c_zero_rk2 = 64'h100000000001C00E;
`endif

    localparam logic [3:0] SBOX [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                         4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

    logic         clk;
    logic         reset;
    logic         keyStart;
    logic [127:0] key;
    logic [4:0]   rk_addr;
    logic [63:0]  rk_out;
    logic         keyDone;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    boron_key_schedule #(.NRK(26), .RKW(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .keyStart (keyStart),
        .key      (key),
        .rk_addr  (rk_addr),
        .rk_out   (rk_out),
        .keyDone  (keyDone),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_step(input logic [127:0] k, input int r);
        logic [127:0] n;
        n = '0;
        for (int b = 0; b < KW; b++) n[(b + 13) % KW] = k[b];
        n[3:0] = SBOX[n[3:0]];
        if (KW == 128) n[7:4] = SBOX[n[7:4]];
        n[63:59] = n[63:59] ^ 5'(r);
        return n;
    endfunction

    function automatic logic [63:0] model_rk(input logic [127:0] kin, input int idx);
        logic [127:0] k;
        k = kin;
        if (KW == 80) k[127:80] = '0;
        for (int r = 1; r <= idx; r++) k = model_step(k, r);
        return k[63:0];
    endfunction

    // Drives one keyStart pulse; returns just after the accepting edge.
    task automatic start_gen(input logic [127:0] k);
        key      = k;
        keyStart = 1'b1;
        @(negedge clk);
        keyStart = 1'b0;
    endtask

    task automatic wait_done(input int already, input string tag);
        int n;
        n = already;
        while (!keyDone && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_latency"}, 64'(n), 64'd26);
    endtask

    task automatic read_rk(input logic [4:0] a, output logic [63:0] v);
        rk_addr = a;
        @(negedge clk);
        v = rk_out;
    endtask

    task automatic sweep(input logic [127:0] k, input string tag);
        logic [63:0] v;
        for (int a = 0; a < 26; a++) begin
            read_rk(5'(a), v);
            check_eq($sformatf("%s_rk%0d", tag, a), v, model_rk(k, a));
        end
    endtask

    initial begin
        logic [63:0]  v;
        logic [127:0] k_rand;
        logic [127:0] k_a, k_b, k_c, k_d, k_e, k_hi;
        int           seen;

        reset = 1'b1; keyStart = 1'b0; key = '0; rk_addr = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_rk_out", rk_out, 64'h0);
        check_eq("reset_keyDone", 64'(keyDone), 64'h0);
        check_eq("reset_busy", 64'(busy), 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // Zero key with hand-computed vectors
        start_gen(128'h0);
        check_eq("zero_busy_after_accept", 64'(busy), 64'h1);
        wait_done(0, "zero");
        check_eq("zero_busy_at_done", 64'(busy), 64'h0);
        @(negedge clk);
        check_eq("zero_done_one_cycle", 64'(keyDone), 64'h0);
        read_rk(5'd0, v); check_eq("zero_rk0", v, 64'h0);
        read_rk(5'd1, v); check_eq("zero_rk1", v, c_zero_rk1);
        read_rk(5'd2, v); check_eq("zero_rk2", v, c_zero_rk2);

        // Random key full sweep plus out-of-range addresses
        k_rand = {$urandom, $urandom, $urandom, $urandom};
        start_gen(k_rand);
        wait_done(0, "rand");
        sweep(k_rand, "rand");
        read_rk(5'd26, v); check_eq("addr26_zero", v, 64'h0);
        read_rk(5'd31, v); check_eq("addr31_zero", v, 64'h0);

        // keyStart mid-generation is ignored; coincident with keyDone is accepted
        k_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        k_b = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
        k_c = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
        start_gen(k_a);
        repeat (4) @(negedge clk);
        key = k_b; keyStart = 1'b1;
        @(negedge clk);
        keyStart = 1'b0;
        wait_done(5, "ignore");
        key = k_c; keyStart = 1'b1;
        @(negedge clk);
        keyStart = 1'b0;
        check_eq("coincident_busy", 64'(busy), 64'h1);
        wait_done(0, "coincident");
        @(negedge clk);
        read_rk(5'd25, v); check_eq("coincident_rk25", v, model_rk(k_c, 25));
        read_rk(5'd7,  v); check_eq("coincident_rk7", v, model_rk(k_c, 7));

        // Ignored-start run: rerun with k_a alone is unnecessary; check k_a result held before overwrite
        start_gen(k_a);
        repeat (4) @(negedge clk);
        key = k_b; keyStart = 1'b1;
        @(negedge clk);
        keyStart = 1'b0;
        wait_done(5, "ignore2");
        read_rk(5'd0,  v); check_eq("ignore_rk0", v, model_rk(k_a, 0));
        read_rk(5'd10, v); check_eq("ignore_rk10", v, model_rk(k_a, 10));
        read_rk(5'd25, v); check_eq("ignore_rk25", v, model_rk(k_a, 25));

        // Reset asserted at E10 aborts generation
        k_d = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        start_gen(k_d);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_busy", 64'(busy), 64'h0);
        check_eq("abort_keyDone", 64'(keyDone), 64'h0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (keyDone) seen++;
        end
        check_eq("abort_no_done", 64'(seen), 64'h0);
        start_gen(k_d);
        wait_done(0, "regen");
        sweep(k_d, "regen");

        // Read-during-write on address 3
        k_e = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
        rk_addr = 5'd3;
        @(negedge clk);
        start_gen(k_e);
        repeat (4) @(negedge clk);
        check_eq("rdw_old_after_e4", rk_out, model_rk(k_d, 3));
        @(negedge clk);
        check_eq("rdw_new_after_e5", rk_out, model_rk(k_e, 3));
        wait_done(5, "rdw");

        // Upper key bits: effective only in the 128-bit build
        k_hi = {48'hA5A5_5A5A_C3C3, 80'h0};
        start_gen(k_hi);
        wait_done(0, "keyhi");
        read_rk(5'd24, v); check_eq("keyhi_rk24", v, model_rk(k_hi, 24));
        read_rk(5'd25, v); check_eq("keyhi_rk25", v, model_rk(k_hi, 25));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
